csync_separator: RTL

Front end of the overlay path. It takes the raw composite sync from the video sync stripper, cleans and synchronizes it, and classifies every low pulse by width. From that it produces the cleaned `csync` and the active-high `vsync` consumed by the crosshair overlay stage. A lock indicator tells the overlay whether the sync stream can be trusted.

---
 rtl/video_pkg.sv | 37 +++
 rtl/sync_filter.sv | 47 ++++
 rtl/csync_separator.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared types and default NTSC timing constants (4 MHz sample clock) for the sync path.
package video_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LINE   = 2'd1,
    VSYNC  = 2'd2
  } sync_state_e;

  typedef enum logic [1:0] {
    RUNT   = 2'd0,
    NORMAL = 2'd1,
    BROAD  = 2'd2
  } pulse_class_e;

  localparam int unsigned GLITCH_CYCLES_DEF = 3;
  localparam int unsigned MIN_PULSE_DEF     = 6;
  localparam int unsigned BROAD_MIN_DEF     = 64;
  localparam int unsigned BROAD_COUNT_DEF   = 2;
  localparam int unsigned VSYNC_MAX_DEF     = 12;
  localparam int unsigned LOCK_PULSES_DEF   = 4;
  localparam int unsigned TIMEOUT_DEF       = 512;

  localparam int unsigned WIDTH_W   = 8;
  localparam int unsigned TIMEOUT_W = 10;
  localparam int unsigned CNT_W     = 8;

  // Saturated widths land in BROAD because 255 is above any sane BROAD_MIN.
  function automatic pulse_class_e classify(input logic [WIDTH_W-1:0] w,
                                            input int unsigned min_pulse,
                                            input int unsigned broad_min);
    if (32'(w) < min_pulse)      return RUNT;
    else if (32'(w) < broad_min) return NORMAL;
    else                         return BROAD;
  endfunction

endpackage

// File: rtl/sync_filter.sv
// Two-flop synchronizer followed by a stability filter: the output only takes a new
// value after GLITCH_CYCLES consecutive identical synchronized samples.
module sync_filter #(
  parameter int unsigned GLITCH_CYCLES = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  localparam int unsigned CNT_W = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;

  logic             sync1_q, sync2_q;
  logic             out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    out_d = out_q;
    cnt_d = '0;
    if (sync2_q != out_q) begin
      if (cnt_q == CNT_W'(GLITCH_CYCLES - 1)) begin
        out_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Idle level of composite sync is high, so everything resets to 1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      out_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
    end
  end

  assign q_o = out_q;

endmodule

// File: rtl/csync_separator.sv
// Composite sync cleaner and pulse-width classifier producing csync, vsync and a lock flag
// for the crosshair overlay.
module csync_separator
  import video_pkg::*;
#(
  parameter int unsigned GLITCH_CYCLES = GLITCH_CYCLES_DEF,
  parameter int unsigned MIN_PULSE     = MIN_PULSE_DEF,
  parameter int unsigned BROAD_MIN     = BROAD_MIN_DEF,
  parameter int unsigned BROAD_COUNT   = BROAD_COUNT_DEF,
  parameter int unsigned VSYNC_MAX     = VSYNC_MAX_DEF,
  parameter int unsigned LOCK_PULSES   = LOCK_PULSES_DEF,
  parameter int unsigned TIMEOUT       = TIMEOUT_DEF
) (
  input  logic clk4mhz,
  input  logic reset_n,
  input  logic csync_in,
  output logic csync,
  output logic vsync,
  output logic sync_lock
);

  logic                 csync_f;
  logic                 prev_q;
  logic [WIDTH_W-1:0]   width_q, width_d;
  logic [TIMEOUT_W-1:0] to_q, to_d;
  logic [CNT_W-1:0]     pulse_cnt_q, pulse_cnt_d;
  logic [CNT_W-1:0]     broad_cnt_q, broad_cnt_d;
  logic [CNT_W-1:0]     vlen_q, vlen_d;
  sync_state_e          state_q, state_d;
  logic                 vsync_q, lock_q;
  logic                 fall_c, rise_c, valid_c, timeout_hit_c;
  pulse_class_e         cls_c;

  sync_filter #(
    .GLITCH_CYCLES(GLITCH_CYCLES)
  ) u_filter (
    .clk_i (clk4mhz),
    .rst_ni(reset_n),
    .d_i   (csync_in),
    .q_o   (csync_f)
  );

  assign fall_c = prev_q & ~csync_f;
  assign rise_c = ~prev_q & csync_f;

  // The falling-edge cycle is already a low cycle, so the count restarts at 1 and
  // equals the low width when the rising edge is seen.
  always_comb begin
    width_d = width_q;
    if (fall_c) begin
      width_d = WIDTH_W'(1);
    end else if (!csync_f && (width_q != '1)) begin
      width_d = width_q + WIDTH_W'(1);
    end
  end

  always_comb begin
    cls_c = RUNT;
    if (rise_c) cls_c = classify(width_q, MIN_PULSE, BROAD_MIN);
  end

  assign valid_c       = (cls_c != RUNT);
  assign timeout_hit_c = !valid_c && (32'(to_q) >= TIMEOUT);

  always_comb begin
    to_d = to_q;
    if (valid_c)         to_d = '0;
    else if (to_q != '1) to_d = to_q + TIMEOUT_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    broad_cnt_d = broad_cnt_q;
    vlen_d      = vlen_q;
    if (timeout_hit_c) begin
      state_d     = SEARCH;
      pulse_cnt_d = '0;
      broad_cnt_d = '0;
      vlen_d      = '0;
    end else if (valid_c) begin
      case (state_q)
        SEARCH: begin
          pulse_cnt_d = pulse_cnt_q + CNT_W'(1);
          if (32'(pulse_cnt_d) >= LOCK_PULSES) begin
            state_d     = LINE;
            pulse_cnt_d = '0;
          end
        end
        LINE: begin
          if (cls_c == BROAD) begin
            broad_cnt_d = broad_cnt_q + CNT_W'(1);
            if (32'(broad_cnt_d) >= BROAD_COUNT) begin
              state_d     = VSYNC;
              vlen_d      = CNT_W'(BROAD_COUNT);
              broad_cnt_d = '0;
            end
          end else begin
            broad_cnt_d = '0;
          end
        end
        VSYNC: begin
          if (cls_c == NORMAL) begin
            state_d     = LINE;
            broad_cnt_d = '0;
          end else begin
            vlen_d = vlen_q + CNT_W'(1);
            if (32'(vlen_d) > VSYNC_MAX) begin
              state_d     = SEARCH;
              pulse_cnt_d = '0;
              broad_cnt_d = '0;
              vlen_d      = '0;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk4mhz or negedge reset_n) begin
    if (!reset_n) begin
      prev_q      <= 1'b1;
      width_q     <= '0;
      to_q        <= '0;
      pulse_cnt_q <= '0;
      broad_cnt_q <= '0;
      vlen_q      <= '0;
      state_q     <= SEARCH;
      vsync_q     <= 1'b0;
      lock_q      <= 1'b0;
    end else begin
      prev_q      <= csync_f;
      width_q     <= width_d;
      to_q        <= to_d;
      pulse_cnt_q <= pulse_cnt_d;
      broad_cnt_q <= broad_cnt_d;
      vlen_q      <= vlen_d;
      state_q     <= state_d;
      vsync_q     <= (state_d == VSYNC);
      lock_q      <= (state_d != SEARCH);
    end
  end

  assign csync     = csync_f;
  assign vsync     = vsync_q;
  assign sync_lock = lock_q;

endmodule
